// File: rtl/multi_note_timer_pkg.sv
// Shared types and defaults for the multi-channel note timer.
// Optional auto-repeat is built when NOTE_TIMER_LOOP_EN is defined.
package note_timer_pkg;

    localparam int NT_NUM_CH = 4;
    localparam int NT_LEN_W  = 6;

    // Storage width of the per-channel count field; LEN_W must not exceed it.
    localparam int NT_MAX_LEN_W = 16;

    typedef struct packed {
        logic [NT_MAX_LEN_W-1:0] count;
        logic                    run;
        logic                    zprev;
    } nt_ch_state_t;

    localparam nt_ch_state_t NT_CH_RST = '{count: '0, run: 1'b0, zprev: 1'b1};

    function automatic int nt_pre_w(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/multi_note_timer_if.sv
// Sequencer <-> note timer bundle; the loop strobe exists only with NOTE_TIMER_LOOP_EN.
interface multi_note_timer_if
    import note_timer_pkg::*;
#(
    parameter int NUM_CH = NT_NUM_CH,
    parameter int LEN_W  = NT_LEN_W
);
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*LEN_W-1:0] load_len;
    logic [NUM_CH-1:0]       play;
    logic [NUM_CH-1:0]       pause;
`ifdef NOTE_TIMER_LOOP_EN
    logic [NUM_CH-1:0]       loop;
`endif
    logic [NUM_CH-1:0]       note_done;
    logic [NUM_CH*LEN_W-1:0] remaining;
    logic [NUM_CH-1:0]       active;

`ifdef NOTE_TIMER_LOOP_EN
    modport master (output load, load_len, play, pause, loop,
                    input  note_done, remaining, active);
    modport slave  (input  load, load_len, play, pause, loop,
                    output note_done, remaining, active);
`else
    modport master (output load, load_len, play, pause,
                    input  note_done, remaining, active);
    modport slave  (input  load, load_len, play, pause,
                    output note_done, remaining, active);
`endif

endinterface

// File: rtl/multi_note_timer_ch.sv
// One note-timer channel: run flag, down-counter, end-of-note detect.
// With NOTE_TIMER_LOOP_EN the last loaded length is kept for auto-repeat.
module note_timer_ch
    import note_timer_pkg::*;
#(
    parameter int LEN_W = NT_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [LEN_W-1:0] load_len,
    input  logic             play,
    input  logic             pause,
`ifdef NOTE_TIMER_LOOP_EN
    input  logic             loop,
`endif
    output logic             note_done,
    output logic [LEN_W-1:0] remaining,
    output logic             active
);

    nt_ch_state_t st, st_n;
    logic         zero;

    assign zero = (st.count == '0);

`ifdef NOTE_TIMER_LOOP_EN
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     len_q <= '0;
        else if (load) len_q <= load_len;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= NT_CH_RST;
        else       st <= st_n;
    end

    always_comb begin
        st_n = st;
        // play wins over pause when both arrive together
        if (play)       st_n.run = 1'b1;
        else if (pause) st_n.run = 1'b0;

        if (load)
            st_n.count = NT_MAX_LEN_W'(load_len);
        else if (st.run && step && !zero)
            st_n.count = st.count - NT_MAX_LEN_W'(1);
`ifdef NOTE_TIMER_LOOP_EN
        else if (st.run && step && loop)
            st_n.count = NT_MAX_LEN_W'(len_q);
`endif

        // a load masks this cycle's zero so a loaded 0 still pulses next cycle
        st_n.zprev = zero & ~load;
    end

    assign note_done = zero & ~st.zprev & ~load;
    assign active    = st.run & ~zero;
    assign remaining = st.count[LEN_W-1:0];

endmodule

// File: rtl/multi_note_timer.sv
// NUM_CH independent note timers stepped by one shared prescaler.
// Build with NOTE_TIMER_LOOP_EN to add per-channel auto-repeat.
module multi_note_timer
    import note_timer_pkg::*;
#(
    parameter int NUM_CH   = NT_NUM_CH,
    parameter int LEN_W    = NT_LEN_W,
    parameter int PRESCALE = 1
) (
    input logic                clk,
    input logic                reset,
    multi_note_timer_if.slave  bus
);

    localparam int PW = nt_pre_w(PRESCALE);

    logic [PW-1:0] pre_cnt;
    logic          step;

    // with PRESCALE=1 the counter sits at 0 and step stays high
    assign step = (pre_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pre_cnt <= '0;
        else if (step) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + PW'(1);
    end

    logic [NUM_CH-1:0][LEN_W-1:0] rem;
    logic [NUM_CH-1:0]            done;
    logic [NUM_CH-1:0]            act;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        note_timer_ch #(.LEN_W(LEN_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .step      (step),
            .load      (bus.load[i]),
            .load_len  (bus.load_len[i*LEN_W +: LEN_W]),
            .play      (bus.play[i]),
            .pause     (bus.pause[i]),
`ifdef NOTE_TIMER_LOOP_EN
            .loop      (bus.loop[i]),
`endif
            .note_done (done[i]),
            .remaining (rem[i]),
            .active    (act[i])
        );
    end

    assign bus.note_done = done;
    assign bus.remaining = rem;
    assign bus.active    = act;

endmodule
